// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operation encodings and the sequencer state type.
package mdu_pkg;

    localparam logic [2:0] MDU_MULTU = 3'b000;
    localparam logic [2:0] MDU_MULT  = 3'b001;
    localparam logic [2:0] MDU_DIVU  = 3'b010;
    localparam logic [2:0] MDU_DIV   = 3'b011;
    localparam logic [2:0] MDU_MTHI  = 3'b100;
    localparam logic [2:0] MDU_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mdu_sign_fix.sv
// Two-lane conditional two's-complement negation; used both to take operand
// magnitudes and to restore result signs.
module mdu_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_val_a,
    input  logic [WIDTH-1:0] i_val_b,
    input  logic             i_neg_a,
    input  logic             i_neg_b,
    output logic [WIDTH-1:0] o_val_a,
    output logic [WIDTH-1:0] o_val_b
);

    logic [WIDTH-1:0] w_val [2];
    logic             w_neg [2];
    logic [WIDTH-1:0] w_res [2];

    assign w_val[0] = i_val_a;
    assign w_val[1] = i_val_b;
    assign w_neg[0] = i_neg_a;
    assign w_neg[1] = i_neg_b;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            assign w_res[gi] = w_neg[gi] ? (~w_val[gi] + WIDTH'(1)) : w_val[gi];
        end
    endgenerate

    assign o_val_a = w_res[0];
    assign o_val_b = w_res[1];

endmodule

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply / restoring divide with HI/LO result registers.
// Signed ops run on magnitudes; signs are restored in a single FIX cycle.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    mdu_state_e         r_state;
    logic [CW-1:0]      r_cnt;
    logic               r_is_div;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic [WIDTH-1:0]   r_in1;
    logic [WIDTH-1:0]   r_a;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;

    logic               w_accept;
    logic               w_start_md;
    logic               w_signed;
    logic [WIDTH-1:0]   w_mag1;
    logic [WIDTH-1:0]   w_mag2;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH+1:0]   w_div_diff;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_fix_in_a;
    logic [2*WIDTH-1:0] w_fix_in_b;
    logic [2*WIDTH-1:0] w_fix_a;
    logic [2*WIDTH-1:0] w_fix_b;
    logic               w_unused_bits;

    assign w_accept   = start & ~cancel & (r_state == ST_IDLE);
    assign w_start_md = w_accept & ~op[2];
    assign w_signed   = op[0];

    mdu_sign_fix #(.WIDTH(WIDTH)) u_entry_fix (
        .i_val_a (in1),
        .i_val_b (in2),
        .i_neg_a (w_signed & in1[WIDTH-1]),
        .i_neg_b (w_signed & in2[WIDTH-1]),
        .o_val_a (w_mag1),
        .o_val_b (w_mag2)
    );

    // Multiply: accumulator holds {partial product, remaining multiplier bits}.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide: accumulator holds {partial remainder, dividend bits / quotient bits}.
    assign w_div_diff = {1'b0, r_acc[2*WIDTH-1:WIDTH-1]} - {2'b00, r_a};
    assign w_div_next = w_div_diff[WIDTH+1] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                            : {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    // Lane A: full product, or zero-extended quotient. Lane B: remainder.
    assign w_fix_in_a = r_is_div ? {{WIDTH{1'b0}}, r_acc[WIDTH-1:0]} : r_acc;
    assign w_fix_in_b = {{WIDTH{1'b0}}, r_acc[2*WIDTH-1:WIDTH]};

    mdu_sign_fix #(.WIDTH(2*WIDTH)) u_result_fix (
        .i_val_a (w_fix_in_a),
        .i_val_b (w_fix_in_b),
        .i_neg_a (r_neg_res),
        .i_neg_b (r_neg_rem),
        .o_val_a (w_fix_a),
        .o_val_b (w_fix_b)
    );

    assign w_unused_bits = ^{w_fix_b[2*WIDTH-1:WIDTH], w_div_diff[WIDTH]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_in1     <= '0;
            r_a       <= '0;
            r_acc     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && op == MDU_MTHI) r_hi <= in1;
                    if (w_accept && op == MDU_MTLO) r_lo <= in1;
                    if (w_start_md) begin
                        r_state   <= ST_RUN;
                        r_busy    <= 1'b1;
                        r_cnt     <= '0;
                        r_is_div  <= op[1];
                        r_in1     <= in1;
                        r_neg_res <= w_signed & (in1[WIDTH-1] ^ in2[WIDTH-1]);
                        r_neg_rem <= w_signed & op[1] & in1[WIDTH-1];
                        r_a       <= op[1] ? w_mag2 : w_mag1;
                        r_acc     <= {{WIDTH{1'b0}}, (op[1] ? w_mag1 : w_mag2)};
                    end
                end
                ST_RUN: begin
                    if (cancel) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_acc <= r_is_div ? w_div_next : w_mul_next;
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == LAST_ITER) r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    if (!cancel) begin
                        r_done <= 1'b1;
                        // Zero divisor: report raw dividend, bypassing sign restoration.
                        if (r_is_div && r_a == '0) begin
                            r_hi <= r_in1;
                            r_lo <= '1;
                        end else if (r_is_div) begin
                            r_hi <= w_fix_b[WIDTH-1:0];
                            r_lo <= w_fix_a[WIDTH-1:0];
                        end else begin
                            r_hi <= w_fix_a[2*WIDTH-1:WIDTH];
                            r_lo <= w_fix_a[WIDTH-1:0];
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
